// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter slice.
//   state_t      : arbiter FSM states
//   err_reason_t : reasons a transaction completes with err=1 (used by benches)
package ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_ERR,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_TIMEOUT
    } err_reason_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
//   req/req_we          : per-requester request and direction (1=write)
//   req_addr/req_wdata  : packed per requester, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   gnt/ack             : one-cycle one-hot grant / completion pulses
//   err/rdata           : completion status and read data, valid with ack
// modport master = requester side, modport slave = arbiter side.
interface ram_arbiter_if #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned NUM_REQ   = 2
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_addr;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           ack;
    logic                         err;
    logic [BUS_WIDTH-1:0]         rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, ack, err, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, ack, err, rdata
    );
endinterface

// File: rtl/ram_arbiter_rr.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index of the last winner; search starts just after it, cyclically
//   onehot : one-hot winner (zero when no request)
//   idx    : winner index
//   valid  : any request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!valid && req[(32'(ptr) + i) % NUM_REQ]) begin
                valid = 1'b1;
                idx   = IW'((32'(ptr) + i) % NUM_REQ);
                onehot[(32'(ptr) + i) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one ram_memory between NUM_REQ requesters, one transaction at a time.
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : requester handshake (req/we/addr/wdata in, gnt/ack/err/rdata out)
//   mem_write_en      : combinational, high only in the WRITE state
//   mem_addr_write    : registered write address to ram_memory
//   mem_data_write    : registered write data to ram_memory
//   mem_addr_read     : registered read address to ram_memory
//   mem_data_read     : read data from ram_memory
//   mem_ready         : read data valid from ram_memory
// Out-of-range addresses complete with err=1 and never touch the RAM; reads that
// see no mem_ready within TIMEOUT cycles complete with err=1 and rdata=0.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned ADDR_BASE = 10,
    parameter int unsigned MEM_SIZE  = 32,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ram_arbiter_if.slave         bus,
    output logic                 mem_write_en,
    output logic [BUS_WIDTH-1:0] mem_addr_write,
    output logic [BUS_WIDTH-1:0] mem_data_write,
    output logic [BUS_WIDTH-1:0] mem_addr_read,
    input  logic [BUS_WIDTH-1:0] mem_data_read,
    input  logic                 mem_ready
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [BUS_WIDTH-1:0] ADDR_LO = BUS_WIDTH'(ADDR_BASE);
    localparam logic [BUS_WIDTH-1:0] ADDR_HI = BUS_WIDTH'(ADDR_BASE + MEM_SIZE - 1);

    // State encoding moved from the shared header's localparams into state_t.
    state_t                state, state_next;
    logic [IW-1:0]         ptr, ptr_next;
    logic [IW-1:0]         owner, owner_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [NUM_REQ-1:0]    gnt_r, gnt_next;
    logic [NUM_REQ-1:0]    ack_r, ack_next;
    logic                  err_r, err_next;
    logic [BUS_WIDTH-1:0]  rdata_r, rdata_next;
    logic [BUS_WIDTH-1:0]  addr_w_next, data_w_next, addr_r_next;

    logic [NUM_REQ-1:0]    win_onehot;
    logic [IW-1:0]         win_idx;
    logic                  win_valid;
    logic [BUS_WIDTH-1:0]  sel_addr, sel_wdata;
    logic                  sel_we, sel_in_range;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    assign sel_addr     = bus.req_addr[win_idx*BUS_WIDTH +: BUS_WIDTH];
    assign sel_wdata    = bus.req_wdata[win_idx*BUS_WIDTH +: BUS_WIDTH];
    assign sel_we       = bus.req_we[win_idx];
    assign sel_in_range = (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI);

    assign mem_write_en = (state == ST_WRITE);
    assign bus.gnt      = gnt_r;
    assign bus.ack      = ack_r;
    assign bus.err      = err_r;
    assign bus.rdata    = rdata_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            ptr            <= IW'(NUM_REQ - 1);
            owner          <= '0;
            cnt            <= '0;
            gnt_r          <= '0;
            ack_r          <= '0;
            err_r          <= 1'b0;
            rdata_r        <= '0;
            mem_addr_write <= '0;
            mem_data_write <= '0;
            mem_addr_read  <= '0;
        end else begin
            state          <= state_next;
            ptr            <= ptr_next;
            owner          <= owner_next;
            cnt            <= cnt_next;
            gnt_r          <= gnt_next;
            ack_r          <= ack_next;
            err_r          <= err_next;
            rdata_r        <= rdata_next;
            mem_addr_write <= addr_w_next;
            mem_data_write <= data_w_next;
            mem_addr_read  <= addr_r_next;
        end
    end

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        owner_next  = owner;
        cnt_next    = cnt;
        gnt_next    = '0;
        ack_next    = '0;
        err_next    = 1'b0;
        rdata_next  = rdata_r;
        addr_w_next = mem_addr_write;
        data_w_next = mem_data_write;
        addr_r_next = mem_addr_read;

        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    ptr_next   = win_idx;
                    owner_next = win_idx;
                    gnt_next   = win_onehot;
                    cnt_next   = '0;
                    if (!sel_in_range) begin
                        state_next = ST_ERR;
                    end else if (sel_we) begin
                        state_next  = ST_WRITE;
                        addr_w_next = sel_addr;
                        data_w_next = sel_wdata;
                    end else begin
                        state_next  = ST_READ;
                        addr_r_next = sel_addr;
                    end
                end
            end
            ST_WRITE: begin
                ack_next[owner] = 1'b1;
                state_next      = ST_DONE;
            end
            ST_READ: begin
                if (mem_ready) begin
                    rdata_next      = mem_data_read;
                    ack_next[owner] = 1'b1;
                    state_next      = ST_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    // cnt counts completed READ cycles, so this is the TIMEOUT-th one
                    rdata_next      = '0;
                    ack_next[owner] = 1'b1;
                    err_next        = 1'b1;
                    state_next      = ST_DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_ERR: begin
                ack_next[owner] = 1'b1;
                err_next        = 1'b1;
                rdata_next      = '0;
                state_next      = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM on the mem_* ports.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write_en;
    logic [31:0] mem_addr_write, mem_data_write, mem_addr_read, mem_data_read;
    logic        mem_ready;
    logic        ready_force;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ram [0:31];

    ram_arbiter_if #(.BUS_WIDTH(32), .NUM_REQ(2)) bus ();

    ram_arbiter #(
        .BUS_WIDTH (32),
        .ADDR_BASE (10),
        .MEM_SIZE  (32),
        .NUM_REQ   (2),
        .TIMEOUT   (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .mem_write_en   (mem_write_en),
        .mem_addr_write (mem_addr_write),
        .mem_data_write (mem_data_write),
        .mem_addr_read  (mem_addr_read),
        .mem_data_read  (mem_data_read),
        .mem_ready      (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en && mem_addr_write >= 32'd10 && mem_addr_write <= 32'd41)
            ram[5'(mem_addr_write - 32'd10)] <= mem_data_write;
    end

    always_comb begin
        mem_data_read = '0;
        if (mem_addr_read >= 32'd10 && mem_addr_read <= 32'd41)
            mem_data_read = ram[5'(mem_addr_read - 32'd10)];
    end

    assign mem_ready = ready_force;

    // Issues one request from requester r and observes it until ack (bounded).
    // Latencies are counted in cycles from the negedge the request is driven.
    task automatic run_txn(input int r, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output int gnt_lat, output int ack_lat,
                           output logic [1:0] gnt_seen, output logic [1:0] ack_seen,
                           output logic e, output logic [31:0] rd, output int wen);
        gnt_lat = -1; ack_lat = -1; gnt_seen = '0; ack_seen = '0;
        e = 1'bx; rd = 'x; wen = 0;
        @(negedge clk);
        bus.req[r]                = 1'b1;
        bus.req_we[r]             = we;
        bus.req_addr[r*32 +: 32]  = addr;
        bus.req_wdata[r*32 +: 32] = wdata;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_write_en) wen++;
            if (bus.gnt != 2'b00 && gnt_lat < 0) begin
                gnt_lat    = c;
                gnt_seen   = bus.gnt;
                bus.req[r] = 1'b0;
            end
            if (bus.ack != 2'b00) begin
                ack_lat  = c;
                ack_seen = bus.ack;
                e        = bus.err;
                rd       = bus.rdata;
                break;
            end
        end
        bus.req[r] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int gl, al, w; logic [1:0] gs, as; logic e; logic [31:0] rd;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.gnt, bus.ack, bus.err, mem_write_en} !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got gnt/ack/err/wen=%b required 000000",
                         {bus.gnt, bus.ack, bus.err, mem_write_en});
            end
            tests_run++;
            if (bus.rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_rdata: got %h required 0", bus.rdata);
            end
        end
        reset = 1'b0;
        run_txn(1, 1'b0, 32'd10, 32'h0, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (gl !== 1 || gs !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_first_gnt: got lat=%0d gnt=%b required lat=1 gnt=10", gl, gs);
        end
        tests_run++;
        if (al !== 2 || as !== 2'b10 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_ack: got lat=%0d ack=%b err=%b required 2/10/0", al, as, e);
        end
    endtask

    task automatic test_write_read();
        int gl, al, w; logic [1:0] gs, as; logic e; logic [31:0] rd;
        run_txn(0, 1'b1, 32'd11, 32'h2, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (gl !== 1 || gs !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_gnt: got lat=%0d gnt=%b required lat=1 gnt=01", gl, gs);
        end
        tests_run++;
        if (w !== 1) begin
            tests_failed++;
            $display("FAIL wr_wen_cycles: got %0d required 1", w);
        end
        tests_run++;
        if (al !== 2 || as !== 2'b01 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_ack: got lat=%0d ack=%b err=%b required 2/01/0", al, as, e);
        end
        run_txn(0, 1'b0, 32'd11, 32'h0, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (al !== 2 || rd !== 32'h2 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_after_wr: got lat=%0d rdata=%h err=%b required 2/00000002/0", al, rd, e);
        end
    endtask

    task automatic test_contention();
        int gl, al, w, n; logic [1:0] gs, as; logic e; logic [31:0] rd;
        logic [1:0]  exp_g [4];
        logic [31:0] exp_d [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{32'hA5, 32'h5A, 32'hA5, 32'h5A};
        run_txn(0, 1'b1, 32'd12, 32'hA5, gl, al, gs, as, e, rd, w);
        run_txn(1, 1'b1, 32'd13, 32'h5A, gl, al, gs, as, e, rd, w);
        pulse_reset();
        bus.req_we   = 2'b00;
        bus.req_addr = {32'd13, 32'd12};
        bus.req      = 2'b11;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin
                tests_run++;
                if (bus.gnt !== exp_g[n]) begin
                    tests_failed++;
                    $display("FAIL contention_gnt%0d: got %b required %b", n, bus.gnt, exp_g[n]);
                end
            end
            if (bus.ack != 2'b00) begin
                tests_run++;
                if (bus.ack !== exp_g[n] || bus.rdata !== exp_d[n] || bus.err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL contention_ack%0d: got ack=%b rdata=%h err=%b required %b/%h/0",
                             n, bus.ack, bus.rdata, bus.err, exp_g[n], exp_d[n]);
                end
                n++;
            end
        end
        bus.req = 2'b00;
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL contention_count: got %0d acks required 4", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_range();
        int gl, al, w; logic [1:0] gs, as; logic e; logic [31:0] rd;
        run_txn(0, 1'b1, 32'd42, 32'h77, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (al !== 2 || e !== 1'b1 || w !== 0) begin
            tests_failed++;
            $display("FAIL range_wr42: got lat=%0d err=%b wen=%0d required 2/1/0", al, e, w);
        end
        run_txn(0, 1'b1, 32'd41, 32'h41, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (e !== 1'b0 || w !== 1) begin
            tests_failed++;
            $display("FAIL range_wr41: got err=%b wen=%0d required 0/1", e, w);
        end
        run_txn(1, 1'b0, 32'd41, 32'h0, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'h41) begin
            tests_failed++;
            $display("FAIL range_rd41: got err=%b rdata=%h required 0/00000041", e, rd);
        end
        run_txn(1, 1'b0, 32'd9, 32'h0, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (e !== 1'b1 || rd !== 32'h0 || as !== 2'b10) begin
            tests_failed++;
            $display("FAIL range_rd9: got err=%b rdata=%h ack=%b required 1/0/10", e, rd, as);
        end
    endtask

    task automatic test_timeout();
        int gl, al, w; logic [1:0] gs, as; logic e; logic [31:0] rd;
        run_txn(0, 1'b0, 32'd41, 32'h0, gl, al, gs, as, e, rd, w);
        ready_force = 1'b0;
        run_txn(1, 1'b0, 32'd20, 32'h0, gl, al, gs, as, e, rd, w);
        ready_force = 1'b1;
        tests_run++;
        if (gl !== 1 || al - gl !== 8) begin
            tests_failed++;
            $display("FAIL timeout_cycles: got gnt_lat=%0d ack_lat=%0d required 1/9", gl, al);
        end
        tests_run++;
        if (e !== 1'b1 || rd !== 32'h0 || as !== 2'b10) begin
            tests_failed++;
            $display("FAIL timeout_status: got err=%b rdata=%h ack=%b required 1/0/10", e, rd, as);
        end
        run_txn(0, 1'b0, 32'd11, 32'h0, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (al !== 2 || e !== 1'b0 || rd !== 32'h2) begin
            tests_failed++;
            $display("FAIL timeout_next: got lat=%0d err=%b rdata=%h required 2/0/00000002", al, e, rd);
        end
    endtask

    task automatic test_reset_midop();
        int gl, al, w; logic [1:0] gs, as; logic e; logic [31:0] rd;
        @(negedge clk);
        bus.req[0]        = 1'b1;
        bus.req_we[0]     = 1'b1;
        bus.req_addr[31:0]  = 32'd15;
        bus.req_wdata[31:0] = 32'h99;
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b01 || mem_write_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_write_cycle: got gnt=%b wen=%b required 01/1", bus.gnt, mem_write_en);
        end
        bus.req[0] = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (bus.ack !== 2'b00 || mem_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_after_reset: got ack=%b wen=%b required 00/0", bus.ack, mem_write_en);
        end
        @(negedge clk);
        tests_run++;
        if (bus.ack !== 2'b00 || mem_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_no_late_ack: got ack=%b wen=%b required 00/0", bus.ack, mem_write_en);
        end
        run_txn(1, 1'b0, 32'd11, 32'h0, gl, al, gs, as, e, rd, w);
        tests_run++;
        if (gl !== 1 || al !== 2 || rd !== 32'h2 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_recover: got gl=%0d al=%0d rdata=%h err=%b required 1/2/00000002/0",
                     gl, al, rd, e);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
        reset         = 1'b0;
        ready_force   = 1'b1;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_range();
        test_timeout();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
